pcm_rom_fetch: RTL

Byte-granular read front-end for the ADPCM sample ROM held in DDR3. Sits between the sound core's PCM ROM request port (18-bit byte address, read strobe, ready) and the 64-bit DDRAM read channel. Holds two 64-bit lines with LRU replacement and prefetches the next sequential line, so streaming sample fetches mostly hit locally. Flushed whenever the ROM is re-downloaded.

---
 rtl/pcm_rom_fetch_if.sv | 33 +++
 rtl/pcm_rom_fetch.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/pcm_rom_fetch_if.sv
// Handshake bundles for the PCM ROM fetch front-end:
// sound-core request port and DDRAM read channel.
interface pcm_req_if;
  logic        rd;
  logic [17:0] addr;
  logic [7:0]  dout;
  logic        rdy;

  modport master (
    output rd, addr,
    input  dout, rdy
  );
  modport slave (
    input  rd, addr,
    output dout, rdy
  );
endinterface

interface ddr_rd_if;
  logic        mem_req;
  logic [17:0] mem_addr;
  logic        mem_ready;
  logic [63:0] mem_dout;

  modport master (
    output mem_req, mem_addr,
    input  mem_ready, mem_dout
  );
  modport slave (
    input  mem_req, mem_addr,
    output mem_ready, mem_dout
  );
endinterface

// File: rtl/pcm_rom_fetch.sv
// Two-line LRU byte cache with next-line prefetch in
// front of the DDRAM-resident ADPCM sample ROM.
module pcm_rom_fetch (
  input  logic      clk_sys,
  input  logic      reset,
  input  logic      flush,
  pcm_req_if.slave  pcm,
  ddr_rd_if.master  mem
);

  typedef enum logic [1:0] {
    IDLE,
    DEMAND,
    PREFETCH
  } state_e;

  state_e            state_q, state_d;
  logic [1:0]        valid_q, valid_d;
  logic [1:0][14:0]  tag_q, tag_d;
  logic [1:0][63:0]  data_q, data_d;
  logic              lru_q, lru_d;
  logic              pf_pend_q, pf_pend_d;
  logic [14:0]       pf_line_q, pf_line_d;
  logic [17:0]       req_addr_q, req_addr_d;
  logic              req_pend_q, req_pend_d;
  logic              kill_q, kill_d;
  logic [7:0]        dout_q, dout_d;
  logic              rdy_q, rdy_d;
  logic              mem_req_q, mem_req_d;
  logic [17:0]       mem_addr_q, mem_addr_d;

  logic              req_v;
  logic [17:0]       req_a;
  logic [14:0]       req_line;
  logic              hit0, hit1;
  logic              serve;
  logic              srv_way;
  logic [14:0]       srv_line;
  logic [2:0]        srv_sel;
  logic [63:0]       srv_data;
  logic [14:0]       nxt;
  logic              nxt_held;

  assign pcm.dout     = dout_q;
  assign pcm.rdy      = rdy_q;
  assign mem.mem_req  = mem_req_q;
  assign mem.mem_addr = mem_addr_q;

  // A request latched during a prefetch outranks a fresh strobe
  assign req_v    = pcm.rd | req_pend_q;
  assign req_a    = req_pend_q ? req_addr_q : pcm.addr;
  assign req_line = req_a[17:3];
  assign hit0     = ~flush & valid_q[0] & (tag_q[0] == req_line);
  assign hit1     = ~flush & valid_q[1] & (tag_q[1] == req_line);

  always_comb begin
    state_d    = state_q;
    valid_d    = valid_q;
    tag_d      = tag_q;
    data_d     = data_q;
    lru_d      = lru_q;
    pf_pend_d  = pf_pend_q;
    pf_line_d  = pf_line_q;
    req_addr_d = req_addr_q;
    req_pend_d = req_pend_q;
    kill_d     = kill_q | (flush & (state_q != IDLE));
    dout_d     = dout_q;
    rdy_d      = 1'b0;
    mem_req_d  = 1'b0;
    mem_addr_d = mem_addr_q;
    serve      = 1'b0;
    srv_way    = 1'b0;
    srv_line   = '0;
    srv_sel    = '0;
    srv_data   = '0;
    nxt        = '0;
    nxt_held   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (req_v) begin
          req_pend_d = 1'b0;
          if (hit0 | hit1) begin
            serve    = 1'b1;
            srv_way  = hit1;
            srv_line = req_line;
            srv_sel  = req_a[2:0];
            srv_data = data_q[hit1];
          end else begin
            req_addr_d = req_a;
            mem_req_d  = 1'b1;
            mem_addr_d = {req_line, 3'b000};
            kill_d     = 1'b0;
            state_d    = DEMAND;
          end
        end else if (pf_pend_q && !flush) begin
          mem_req_d  = 1'b1;
          mem_addr_d = {pf_line_q, 3'b000};
          kill_d     = 1'b0;
          state_d    = PREFETCH;
        end
      end
      DEMAND: begin
        if (mem.mem_ready) begin
          valid_d[lru_q] = ~(kill_q | flush);
          tag_d[lru_q]   = req_addr_q[17:3];
          data_d[lru_q]  = mem.mem_dout;
          serve          = 1'b1;
          srv_way        = lru_q;
          srv_line       = req_addr_q[17:3];
          srv_sel        = req_addr_q[2:0];
          srv_data       = mem.mem_dout;
          state_d        = IDLE;
        end
      end
      PREFETCH: begin
        if (pcm.rd) begin
          req_pend_d = 1'b1;
          req_addr_d = pcm.addr;
        end
        if (mem.mem_ready) begin
          valid_d[lru_q] = ~(kill_q | flush);
          tag_d[lru_q]   = mem_addr_q[17:3];
          data_d[lru_q]  = mem.mem_dout;
          pf_pend_d      = 1'b0;
          state_d        = IDLE;
          // A waiting request for this very line completes on the fill
          if (req_v && !(kill_q | flush) &&
              req_line == mem_addr_q[17:3]) begin
            req_pend_d = 1'b0;
            serve      = 1'b1;
            srv_way    = lru_q;
            srv_line   = req_line;
            srv_sel    = req_a[2:0];
            srv_data   = mem.mem_dout;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (serve) begin
      rdy_d    = 1'b1;
      dout_d   = srv_data[{srv_sel, 3'b000} +: 8];
      lru_d    = ~srv_way;
      nxt      = srv_line + 15'd1;
      nxt_held = (valid_d[0] && tag_d[0] == nxt) ||
                 (valid_d[1] && tag_d[1] == nxt);
      if (!nxt_held) begin
        pf_pend_d = 1'b1;
        pf_line_d = nxt;
      end
    end

    if (flush) begin
      valid_d   = '0;
      pf_pend_d = 1'b0;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q    <= IDLE;
      valid_q    <= '0;
      tag_q      <= '0;
      data_q     <= '0;
      lru_q      <= 1'b0;
      pf_pend_q  <= 1'b0;
      pf_line_q  <= '0;
      req_addr_q <= '0;
      req_pend_q <= 1'b0;
      kill_q     <= 1'b0;
      dout_q     <= '0;
      rdy_q      <= 1'b0;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      valid_q    <= valid_d;
      tag_q      <= tag_d;
      data_q     <= data_d;
      lru_q      <= lru_d;
      pf_pend_q  <= pf_pend_d;
      pf_line_q  <= pf_line_d;
      req_addr_q <= req_addr_d;
      req_pend_q <= req_pend_d;
      kill_q     <= kill_d;
      dout_q     <= dout_d;
      rdy_q      <= rdy_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
    end
  end

endmodule
